capture_ctrl: RTL

//  Capture controller on the far side of the trigger interface. Issues arm/abort

---
 rtl/capture_ctrl.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/capture_ctrl.sv
// capture_ctrl: drives the trigger unit (arm/abort), records samples into a
// circular buffer around the trigger point, then streams the captured window
// out oldest-first over a valid/ready port.
`timescale 1ns/1ps

module capture_ctrl #(
    parameter int DSIZE  = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] pre_count,
    input  logic [ADDR_W-1:0] post_count,
    input  logic              sample_en,
    input  logic [DSIZE-1:0]  dinput,
    output logic              trig_arm,
    output logic              trig_abort,
    output logic              trig_ignore,
    input  logic              trig_armed,
    input  logic              triggered,
    output logic [DSIZE-1:0]  rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              rd_last,
    output logic              busy,
    output logic              capture_done,
    output logic [ADDR_W-1:0] trig_addr
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRE     = 3'd1,
        S_ARMED   = 3'd2,
        S_POST    = 3'd3,
        S_READOUT = 3'd4
    } state_t;

    state_t state;
    state_t state_d;

    // Sample buffer and write side
    logic [DSIZE-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] pre_q;
    logic [ADDR_W-1:0] post_q;
    logic [ADDR_W-1:0] win_cnt;
    logic [ADDR_W-1:0] win_next;
    logic              trig_pend;
    logic [1:0]        arm_age;
    logic              rearmed;

    // Readout side
    logic [ADDR_W-1:0] rd_addr;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  n_beats;
    logic [DSIZE-1:0]  data_p1;
    logic              vld_p1;
    logic              last_p1;

    // Decoded control
    logic wr_en;
    logic trig_hit;
    logic repulse;
    logic arm_fire;
    logic abort_fire;
    logic start_acc;
    logic out_free;
    logic move_p1;
    logic issue;
    logic final_beat;

    // Post window saturates so that pre + trigger + post never exceeds the
    // buffer depth; ~pre equals (DEPTH-1-pre) in ADDR_W bits.
    function automatic logic [ADDR_W-1:0] sat_post(input logic [ADDR_W-1:0] pre,
                                                   input logic [ADDR_W-1:0] post);
        logic [ADDR_W-1:0] room;
        room = ~pre;
        return (post > room) ? room : post;
    endfunction

    assign win_next   = ADDR_W'(win_cnt + 1'b1);
    assign start_acc  = (state == S_IDLE) && start && !stop;
    assign out_free   = !rd_valid || rd_ready;
    assign move_p1    = vld_p1 && out_free;
    assign issue      = (state == S_READOUT) && (issue_cnt != n_beats) && (!vld_p1 || out_free);
    assign final_beat = rd_valid && rd_ready && rd_last;
    assign busy       = (state != S_IDLE);
    assign arm_fire   = ((state_d == S_ARMED) && (state != S_ARMED)) || repulse;
    assign abort_fire = stop && ((state == S_ARMED) || (state == S_POST));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state decode plus the per-state write enable and trigger handling
    always_comb begin
        state_d     = state;
        wr_en       = 1'b0;
        trig_hit    = 1'b0;
        repulse     = 1'b0;
        trig_ignore = 1'b1;
        case (state)
            S_IDLE: begin
                if (start && !stop) begin
                    state_d = (pre_count == '0) ? S_ARMED : S_PRE;
                end
            end
            S_PRE: begin
                wr_en = sample_en;
                if (stop) begin
                    state_d = S_IDLE;
                end else if (sample_en && (win_next == pre_q)) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                wr_en       = sample_en;
                trig_ignore = !sample_en;
                trig_hit    = sample_en && (triggered || trig_pend) && !stop;
                if (stop) begin
                    state_d = S_IDLE;
                end else if (trig_hit) begin
                    state_d = S_POST;
                end else begin
                    // Trigger unit did not acknowledge the arm: try once more
                    repulse = !trig_arm && (arm_age >= 2'd2) && !trig_armed && !rearmed;
                end
            end
            S_POST: begin
                // Writes stop once the post window is full so the oldest
                // pre-trigger sample is never overwritten.
                wr_en = sample_en && (win_cnt != post_q);
                if (stop) begin
                    state_d = S_IDLE;
                end else if ((win_cnt == post_q) || (wr_en && (win_next == post_q))) begin
                    state_d = S_READOUT;
                end
            end
            S_READOUT: begin
                if (stop || final_beat) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Capture-side control: pointers, window counters, trigger bookkeeping, pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr         <= '0;
            pre_q        <= '0;
            post_q       <= '0;
            win_cnt      <= '0;
            trig_pend    <= 1'b0;
            trig_addr    <= '0;
            arm_age      <= '0;
            rearmed      <= 1'b0;
            trig_arm     <= 1'b0;
            trig_abort   <= 1'b0;
            capture_done <= 1'b0;
        end else begin
            trig_arm     <= arm_fire;
            trig_abort   <= abort_fire;
            capture_done <= final_beat && !stop && (state == S_READOUT);

            if (start_acc) begin
                pre_q   <= pre_count;
                post_q  <= sat_post(pre_count, post_count);
                rearmed <= 1'b0;
            end else if (repulse) begin
                rearmed <= 1'b1;
            end

            if (start_acc) begin
                wptr <= '0;
            end else if (wr_en) begin
                wptr <= ADDR_W'(wptr + 1'b1);
            end

            if (state_d != state) begin
                win_cnt <= '0;
            end else if (wr_en) begin
                win_cnt <= win_next;
            end

            if (state_d != state) begin
                trig_pend <= 1'b0;
            end else if ((state == S_ARMED) && triggered && !sample_en && !stop) begin
                trig_pend <= 1'b1;
            end

            if (trig_hit) begin
                trig_addr <= wptr;
            end

            if (state == S_ARMED) begin
                if (trig_arm) begin
                    arm_age <= 2'd1;
                end else if (arm_age != 2'd3) begin
                    arm_age <= arm_age + 2'd1;
                end
            end
        end
    end

    // Buffer write port and synchronous read port (stage p1)
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr] <= dinput;
        end
        if (issue) begin
            data_p1 <= mem[rd_addr];
        end
    end

    // Readout: read issue into p1, then p1 -> output register with backpressure
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr   <= '0;
            issue_cnt <= '0;
            n_beats   <= '0;
            vld_p1    <= 1'b0;
            last_p1   <= 1'b0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            rd_data   <= '0;
        end else if ((state == S_POST) && (state_d == S_READOUT)) begin
            rd_addr   <= ADDR_W'(trig_addr - pre_q);
            issue_cnt <= '0;
            n_beats   <= CNT_W'(pre_q) + CNT_W'(post_q) + CNT_W'(1);
            vld_p1    <= 1'b0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
        end else if (state_d != S_READOUT) begin
            vld_p1   <= 1'b0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
        end else begin
            // ---- stage p1: RAM read issued, data lands in data_p1 ----
            if (issue) begin
                rd_addr   <= ADDR_W'(rd_addr + 1'b1);
                issue_cnt <= CNT_W'(issue_cnt + 1'b1);
                vld_p1    <= 1'b1;
                last_p1   <= (CNT_W'(issue_cnt + 1'b1) == n_beats);
            end else if (move_p1) begin
                vld_p1 <= 1'b0;
            end
            // ---- stage p2: output register, held while stalled ----
            if (move_p1) begin
                rd_valid <= 1'b1;
                rd_data  <= data_p1;
                rd_last  <= last_p1;
            end else if (rd_valid && rd_ready) begin
                rd_valid <= 1'b0;
                rd_last  <= 1'b0;
            end
        end
    end

endmodule
